// File: rtl/conv_encoder_k3.sv
// rtl/conv_encoder_k3.sv - rate-1/2 K=3 convolutional encoder (G0=7, G1=5), one codeword per clock
// Zero-tail termination is built in when CONV_ENC_TAIL_EN is defined.
module conv_encoder_k3 #(
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 st,
  input  logic [FRAME_LEN-1:0] data_in,
  output logic [1:0]           code_out,
  output logic                 code_valid,
  output logic                 busy,
  output logic                 done
);

`ifdef CONV_ENC_TAIL_EN
  typedef enum logic [1:0] {IDLE, ENCODE, TAIL, DONE} state_t;
  localparam logic [CNT_W-1:0] LAST_TAIL = CNT_W'(FRAME_LEN + 1);
`else
  typedef enum logic [1:0] {IDLE, ENCODE, DONE} state_t;
`endif

  localparam logic [CNT_W-1:0] LAST_MSG = CNT_W'(FRAME_LEN - 1);

  state_t               state, state_nxt;
  logic [FRAME_LEN-1:0] frame, frame_nxt;
  logic [1:0]           sr, sr_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [1:0]           code_nxt;
  logic                 valid_nxt, busy_nxt, done_nxt;

  // {c0, c1} for input bit u given history s = {previous bit, bit before that}
  function automatic logic [1:0] encode(input logic u, input logic [1:0] s);
    encode = {u ^ s[1] ^ s[0], u ^ s[0]};
  endfunction

  always_comb begin
    state_nxt = state;
    frame_nxt = frame;
    sr_nxt    = sr;
    cnt_nxt   = cnt;
    code_nxt  = code_out;
    valid_nxt = 1'b0;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (st) begin
          frame_nxt = data_in;
          sr_nxt    = 2'b00;
          cnt_nxt   = '0;
          state_nxt = ENCODE;
        end
      end
      ENCODE: begin
        // frame shifts left so the MSB is always the current message bit
        code_nxt  = encode(frame[FRAME_LEN-1], sr);
        sr_nxt    = {frame[FRAME_LEN-1], sr[1]};
        frame_nxt = frame << 1;
        cnt_nxt   = cnt + 1'b1;
        valid_nxt = 1'b1;
        busy_nxt  = 1'b1;
        if (cnt == LAST_MSG) begin
`ifdef CONV_ENC_TAIL_EN
          state_nxt = TAIL;
`else
          state_nxt = DONE;
`endif
        end
      end
`ifdef CONV_ENC_TAIL_EN
      TAIL: begin
        code_nxt  = encode(1'b0, sr);
        sr_nxt    = {1'b0, sr[1]};
        cnt_nxt   = cnt + 1'b1;
        valid_nxt = 1'b1;
        busy_nxt  = 1'b1;
        if (cnt == LAST_TAIL) begin
          state_nxt = DONE;
        end
      end
`endif
      DONE: begin
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      frame      <= '0;
      sr         <= 2'b00;
      cnt        <= '0;
      code_out   <= 2'b00;
      code_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      frame      <= frame_nxt;
      sr         <= sr_nxt;
      cnt        <= cnt_nxt;
      code_out   <= code_nxt;
      code_valid <= valid_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
    end
  end

endmodule

// File: tb/tb_conv_encoder_k3.sv
// tb/tb_conv_encoder_k3.sv - scoreboard bench for conv_encoder_k3 against a bit-list convolution model
module tb_conv_encoder_k3;
  localparam int FL = 8;
`ifdef CONV_ENC_TAIL_EN
  localparam int NTAIL = 2;
`else
  localparam int NTAIL = 0;
`endif
  localparam int N = FL + NTAIL;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          st  = 1'b0;
  logic [FL-1:0] data_in = '0;
  logic [1:0]    code_out;
  logic          code_valid, busy, done;

  int         checks = 0;
  int         errors = 0;
  logic [1:0] exp_q[$];
  logic [1:0] last_cw = 2'b00;
  logic [1:0] mon_exp;

  // reference codeword streams for 1011_0000 and FF with two tail bits
  logic [1:0] vec [0:1][0:9] = '{
    '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00},
    '{2'b11, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b11}
  };

  always #5 clk = ~clk;

  conv_encoder_k3 #(.FRAME_LEN(FL), .CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .st         (st),
    .data_in    (data_in),
    .code_out   (code_out),
    .code_valid (code_valid),
    .busy       (busy),
    .done       (done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (code_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_codeword: got %b expected none", code_out);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("codeword", 32'(code_out), 32'(mon_exp));
      end
    end
  end

  // Model: message bits MSB first, then NTAIL zeros, history starts at zero;
  // c0 = parity of the last three bits, c1 = parity of current and two-back.
  task automatic push_model(input logic [FL-1:0] d, input int limit);
    int b[FL+2];
    int s0, s1;
    logic [1:0] cw;
    for (int i = 0; i < FL + 2; i++) b[i] = (i < FL) ? int'(d[FL-1-i]) : 0;
    for (int i = 0; i < N && i < limit; i++) begin
      s0 = b[i] + ((i >= 1) ? b[i-1] : 0) + ((i >= 2) ? b[i-2] : 0);
      s1 = b[i] + ((i >= 2) ? b[i-2] : 0);
      cw = {(s0 % 2) == 1, (s1 % 2) == 1};
      exp_q.push_back(cw);
      last_cw = cw;
    end
  endtask

  task automatic push_vec(input int which);
    for (int i = 0; i < N; i++) begin
      exp_q.push_back(vec[which][i]);
      last_cw = vec[which][i];
    end
  endtask

  // Called at a negedge; the next posedge is the accept edge.
  task automatic run_frame(input logic [FL-1:0] d, input bit hold, input string tag);
    st      = 1'b1;
    data_in = d;
    @(negedge clk);
    if (!hold) st = 1'b0;
    data_in = FL'($urandom);
    chk({tag, "_busy_at_accept"}, 32'(busy), 0);
    chk({tag, "_valid_at_accept"}, 32'(code_valid), 0);
    for (int k = 1; k <= N; k++) begin
      @(negedge clk);
      data_in = FL'($urandom);
      chk({tag, "_busy"}, 32'(busy), 1);
      chk({tag, "_valid"}, 32'(code_valid), 1);
      chk({tag, "_no_early_done"}, 32'(done), 0);
    end
    @(negedge clk);
    chk({tag, "_done"}, 32'(done), 1);
    chk({tag, "_busy_at_done"}, 32'(busy), 0);
    chk({tag, "_valid_at_done"}, 32'(code_valid), 0);
    chk({tag, "_code_hold"}, 32'(code_out), 32'(last_cw));
    if (!hold) begin
      @(negedge clk);
      chk({tag, "_done_one_cycle"}, 32'(done), 0);
    end
  endtask

  initial begin
    logic [FL-1:0] d;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_code_out", 32'(code_out), 0);
    chk("reset_valid", 32'(code_valid), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    rst = 1'b0;
    @(negedge clk);

    push_vec(0);
    run_frame(8'b1011_0000, 1'b0, "s1");
    push_vec(1);
    run_frame(8'hFF, 1'b0, "s2");

    // st held across a whole frame, then the back-to-back frame must restart from sr=00
    push_vec(1);
    run_frame(8'hFF, 1'b1, "hold1");
    push_model(8'hC3, N);
    run_frame(8'hC3, 1'b0, "hold2");

    // reset after the 4th codeword
    push_model(8'b1011_0000, 4);
    st = 1'b1;
    data_in = 8'b1011_0000;
    @(negedge clk);
    st = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_valid", 32'(code_valid), 0);
    chk("rst_mid_code", 32'(code_out), 0);
    chk("rst_mid_done", 32'(done), 0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_mid_no_done", 32'(done), 0);
    end
    push_vec(0);
    run_frame(8'b1011_0000, 1'b0, "s1_again");

    // rst and st on the same edge
    rst = 1'b1;
    st = 1'b1;
    data_in = FL'($urandom);
    @(negedge clk);
    rst = 1'b0;
    st = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_st_busy", 32'(busy), 0);
      chk("rst_st_valid", 32'(code_valid), 0);
    end

    for (int f = 0; f < 20; f++) begin
      d = FL'($urandom);
      push_model(d, N);
      run_frame(d, 1'b0, "rand");
    end
    d = FL'($urandom) | 8'h80;
    push_model(d, N);
    run_frame(d, 1'b1, "rand_hold1");
    d = FL'($urandom);
    push_model(d, N);
    run_frame(d, 1'b0, "rand_hold2");

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
